multi_byte_serial_adder: RTL

Byte-serial multi-precision adder that sits directly upstream of the 8-bit ripple-carry adder. It latches two wide operands and a carry-in on a start pulse, then feeds the adder one byte pair per clock, least-significant byte first. Each cycle it registers the adder's sum byte into the result and feeds the adder's carry-out back as the next byte's carry-in. The block reuses a single `eight_bit_ripple_carry_adder` instance, with port order (sum, cout, a, b, cin), instead of a wide combinational adder.

---
 rtl/multi_byte_serial_adder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/multi_byte_serial_adder.sv
// Byte-serial multi-precision adder: latches wide operands on start and
// sums them one byte per clock, LSB first, through one 8-bit ripple adder.
//
// Ports:
//   clk   - clock, all state updates on rising edge
//   rst   - synchronous active-high reset
//   start - begin an addition (accepted in IDLE or DONE)
//   a, b  - W-bit operands, sampled on accepted start
//   cin   - carry into byte 0, sampled on accepted start
//   busy  - high while bytes are being processed
//   done  - one-cycle pulse, sum/cout final
//   sum   - W-bit result register
//   cout  - carry out of the most-significant byte

module eight_bit_ripple_carry_adder (
    output logic [7:0] sum,
    output logic       cout,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin
);
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module multi_byte_serial_adder #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic [IW-1:0]  idx_q, idx_d;

    logic [7:0]     add_a, add_b, add_s;
    logic           add_co;

    // Byte-select mux feeding the single shared adder.
    assign add_a = a_q[int'(idx_q)*8 +: 8];
    assign add_b = b_q[int'(idx_q)*8 +: 8];

    eight_bit_ripple_carry_adder u_add (
        add_s,
        add_co,
        add_a,
        add_b,
        carry_q
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*8 +: 8] = add_s;
                carry_d = add_co;
                if (idx_q == IW'(NBYTES - 1)) begin
                    cout_d  = add_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule
